// File: rtl/mem_responder.sv
// Memory-side responder: accepts one load/store at a time, inserts WAIT wait
// states, drives a single-port synchronous SRAM and returns formatted read data.
module mem_responder #(
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 1024,
  parameter int WAIT      = 2,
  localparam int AW       = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              stall,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [AW-1:0]     mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_CAPTURE
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [1:0]    lane_q, lane_d;
  logic [AW-1:0] widx_q, widx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;

  logic          req_err;
  logic [31:0]   shifted;
  logic [31:0]   fmt_rdata;
  logic [3:0]    be;
  logic [31:0]   rep_wdata;

  // Any address bit above the SRAM's byte range makes the access out of range.
  assign req_err = (req_size == 2'b11) ||
                   ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                   ((req_addr >> (AW + 2)) != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      lane_q      <= '0;
      widx_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      lane_q      <= lane_d;
      widx_q      <= widx_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lane_d      = lane_q;
    widx_d      = widx_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          lane_d  = req_addr[1:0];
          widx_d  = req_addr[AW+1:2];
          wdata_d = req_wdata;
          if (req_err) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (WAIT == 0) begin
            state_d = ST_ACCESS;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_CNT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_ACCESS;
      end
      ST_ACCESS: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = we_q ? 32'd0 : fmt_rdata;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Right-align the addressed lane; halves are always on an even lane here.
  always_comb begin
    shifted = mem_rdata >> {lane_q, 3'b000};
    case (size_q)
      2'b00:   fmt_rdata = uns_q ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   fmt_rdata = uns_q ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: fmt_rdata = mem_rdata;
    endcase
  end

  always_comb begin
    case (size_q)
      2'b00: begin
        be        = 4'b0001 << lane_q;
        rep_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be        = lane_q[1] ? 4'b1100 : 4'b0011;
        rep_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        rep_wdata = wdata_q;
      end
    endcase
  end

  assign stall     = (state_q != ST_IDLE);
  assign mem_cs    = (state_q == ST_ACCESS);
  assign mem_we    = mem_cs & we_q;
  assign mem_be    = mem_cs ? be : 4'b0000;
  assign mem_addr  = mem_cs ? widx_q : '0;
  assign mem_wdata = mem_cs ? rep_wdata : 32'd0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
